inst_fetch_unit: RTL and testbench

//  Instruction fetch stage between instruction memory and processor decode.

---
 rtl/inst_fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage between instruction memory and decode. It owns the
// fetch PC and issues sequential word requests, keeping no more than DEPTH
// words either buffered or in flight. Returned words are stored together with
// their PCs in a show-ahead prefetch FIFO. A branch redirect flushes the FIFO
// and marks every in-flight response as stale, so those words are dropped
// when they come back.
//
// Ports
//   clk          in   1   clock, rising edge
//   pc_reset     in   1   synchronous reset, active low
//   pc_enable    in   1   new fetch requests may be issued
//   redirect     in   1   flush and restart fetch at redirect_pc
//   redirect_pc  in   32  redirect target (bits [1:0] ignored)
//   imem_req     out  1   request valid (memory accepts every request)
//   imem_addr    out  32  word address of the request
//   imem_rvalid  in   1   response valid, responses return in order
//   imem_rdata   in   32  response instruction word
//   instr        out  32  head-of-FIFO instruction
//   instr_pc     out  32  PC of instr
//   instr_valid  out  1   instr / instr_pc valid
//   instr_ready  in   1   decode accepts instr this cycle
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        pc_reset,
  input  logic        pc_enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_S = (CW + 1)'(DEPTH);

  // Registered state
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  // Next-state values
  logic [31:0]   fetch_pc_nxt;
  logic [31:0]   resp_pc_nxt;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW-1:0] wr_ptr_nxt;
  logic [CW-1:0] fifo_count_nxt;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard_nxt;

  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          issue;
  logic          resp_take;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [31:0]   redirect_target;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_N);

  // Buffered plus in-flight words may never exceed DEPTH, which guarantees
  // every response has a free FIFO slot when it arrives.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok  = (credit_sum < DEPTH_S);

  assign issue     = pc_reset & pc_enable & ~redirect & credit_ok;
  // A response with nothing outstanding is a leftover from before a reset.
  assign resp_take = imem_rvalid & (outstanding != '0);
  assign push      = resp_take & ~redirect & (discard == '0);
  assign pop       = instr_valid & instr_ready & ~redirect;

  // Outputs are forced to zero while reset is asserted.
  assign imem_req    = issue;
  assign imem_addr   = pc_reset ? fetch_pc : 32'h0;
  assign instr_valid = pc_reset & ~fifo_empty;
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'h0;

  always_comb begin
    outstanding_nxt = outstanding;
    if (issue && !resp_take) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (!issue && resp_take) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  always_comb begin
    fetch_pc_nxt   = fetch_pc;
    resp_pc_nxt    = resp_pc;
    rd_ptr_nxt     = rd_ptr;
    wr_ptr_nxt     = wr_ptr;
    fifo_count_nxt = fifo_count;
    discard_nxt    = discard;

    if (redirect) begin
      fetch_pc_nxt   = redirect_target;
      resp_pc_nxt    = redirect_target;
      rd_ptr_nxt     = '0;
      wr_ptr_nxt     = '0;
      fifo_count_nxt = '0;
      // Everything still in flight after this cycle belongs to the old path.
      // No issue happens in a redirect cycle, so this already counts any
      // response consumed this cycle.
      discard_nxt    = outstanding_nxt;
    end else begin
      if (issue) begin
        fetch_pc_nxt = fetch_pc + 32'd4;
      end
      if (resp_take && (discard != '0)) begin
        discard_nxt = discard - CW'(1);
      end
      if (push) begin
        resp_pc_nxt = resp_pc + 32'd4;
        wr_ptr_nxt  = wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        fifo_count_nxt = fifo_count + CW'(1);
      end else if (!push && pop) begin
        fifo_count_nxt = fifo_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!pc_reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      fifo_count  <= fifo_count_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  // Storage needs no reset: the occupancy count decides what is visible.
  always_ff @(posedge clk) begin
    if (pc_reset && push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!pc_reset)
    !(push && fifo_full));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios followed by a randomized run,
// all checked against a queue-based reference model and an in-order memory.
module tb_inst_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        pc_reset;
  logic        pc_enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .pc_reset    (pc_reset),
    .pc_enable   (pc_enable),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // in-order memory: pending request addresses and the cycle each answers in
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;

  // reference model
  logic [31:0] m_fetch, m_resp;
  logic [31:0] mf_pc[$];
  logic [31:0] mf_data[$];
  int          m_out, m_disc;

  // observation logs
  logic [31:0] seen_pc[$];
  logic [31:0] seen_data[$];
  logic [31:0] addr_log[$];
  int          first_valid;
  int          rel;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fetch = RESET_PC;
    m_resp  = RESET_PC;
    mf_pc.delete();
    mf_data.delete();
    m_out  = 0;
    m_disc = 0;
  endtask

  task automatic model_update(input logic rv, input logic req);
    logic take;
    if (!pc_reset) begin
      model_reset();
    end else begin
      take = rv && (m_out > 0);
      if (redirect) begin
        if (take) m_out--;
        m_disc = m_out;
        mf_pc.delete();
        mf_data.delete();
        m_fetch = redirect_pc & ~32'h3;
        m_resp  = m_fetch;
      end else begin
        if (mf_pc.size() > 0 && instr_ready) begin
          void'(mf_pc.pop_front());
          void'(mf_data.pop_front());
        end
        if (take) begin
          m_out--;
          if (m_disc > 0) m_disc--;
          else begin
            mf_pc.push_back(m_resp);
            mf_data.push_back(mem_word(m_resp));
            m_resp = m_resp + 32'd4;
          end
        end
        if (req) begin
          m_fetch = m_fetch + 32'd4;
          m_out++;
        end
      end
    end
  endtask

  task automatic cycle();
    logic        rv, m_req, e_valid;
    logic [31:0] rd;
    int          d;
    rv = 1'b0;
    rd = 32'h0;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      rv = 1'b1;
      rd = mem_word(mq_addr[0]);
    end
    imem_rvalid = rv;
    imem_rdata  = rd;
    @(negedge clk);
    m_req   = pc_reset && pc_enable && !redirect && ((mf_pc.size() + m_out) < DEPTH);
    e_valid = pc_reset && (mf_pc.size() > 0);
    check("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check("imem_addr", imem_addr, m_fetch);
    check("instr_valid", 32'(instr_valid), 32'(e_valid));
    check("instr_pc", instr_pc, e_valid ? mf_pc[0] : 32'h0);
    check("instr", instr, e_valid ? mf_data[0] : 32'h0);
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (instr_valid && instr_ready && !redirect && pc_reset) begin
      seen_pc.push_back(instr_pc);
      seen_data.push_back(instr);
    end
    if (rv) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (imem_req) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq_addr.push_back(imem_addr);
      mq_due.push_back(d);
      addr_log.push_back(imem_addr);
    end
    model_update(rv, m_req);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    seen_pc.delete();
    seen_data.delete();
    addr_log.delete();
    first_valid = -1;
  endtask

  task automatic do_reset(input int n, input bit flush);
    pc_reset = 1'b0;
    repeat (n) cycle();
    pc_reset = 1'b1;
    if (flush) begin
      mq_addr.delete();
      mq_due.delete();
      last_due = cyc;
    end
    clear_logs();
    rel = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pc_reset    = 1'b0;
    pc_enable   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    model_reset();
    clear_logs();

    // 1: streaming with 1-cycle memory
    lat_min = 1; lat_max = 1;
    do_reset(2, 1);
    repeat (8) cycle();
    check("s1_first_valid", 32'(first_valid), 32'(rel + 2));
    for (int i = 0; i < 6; i++) check("s1_addr", qget(addr_log, i), 32'(4 * i));
    check("s1_npop", 32'(seen_pc.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("s1_pc", qget(seen_pc, i), 32'(4 * i));

    // 2: back-pressure fills exactly DEPTH credits
    instr_ready = 1'b0;
    do_reset(2, 1);
    repeat (8) cycle();
    check("s2_nreq", 32'(addr_log.size()), 32'(DEPTH));
    check("s2_req_stalled", 32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    repeat (8) cycle();
    for (int i = 0; i < 5; i++) check("s2_pc", qget(seen_pc, i), 32'(4 * i));

    // 3: redirect with two stale words in flight
    lat_min = 3; lat_max = 3;
    do_reset(2, 1);
    cycle(); cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0;
    repeat (12) cycle();
    check("s3_addr_after", qget(addr_log, 2), 32'h100);
    check("s3_pc0", qget(seen_pc, 0), 32'h100);
    check("s3_data0", qget(seen_data, 0), mem_word(32'h100));
    check("s3_pc1", qget(seen_pc, 1), 32'h104);

    // 4: fetch gating
    lat_min = 1; lat_max = 1;
    do_reset(2, 1);
    repeat (3) cycle();
    pc_enable = 1'b0;
    repeat (6) cycle();
    check("s4_nreq", 32'(addr_log.size()), 32'd3);
    check("s4_ndrain", 32'(seen_pc.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("s4_pc", qget(seen_pc, i), 32'(4 * i));
    pc_enable = 1'b1;
    cycle();
    check("s4_resume", qget(addr_log, 3), 32'hC);

    // 5: misaligned redirect coinciding with pop and response
    do_reset(2, 1);
    repeat (4) cycle();
    check("s5_pre_valid", 32'(instr_valid), 32'd1);
    seen_pc.delete();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect = 1'b0;
    check("s5_valid_after", 32'(instr_valid), 32'd0);
    repeat (8) cycle();
    check("s5_pc0", qget(seen_pc, 0), 32'h100);
    check("s5_pc1", qget(seen_pc, 1), 32'h104);

    // 6: reset with two responses in flight, strays arrive afterwards
    lat_min = 3; lat_max = 3;
    do_reset(2, 1);
    cycle(); cycle();
    pc_enable = 1'b0;
    pc_reset  = 1'b0;
    cycle();
    pc_reset = 1'b1;
    check("s6_valid_after_rst", 32'(instr_valid), 32'd0);
    repeat (3) cycle();
    check("s6_strays_ignored", 32'(instr_valid), 32'd0);
    pc_enable = 1'b1;
    clear_logs();
    repeat (10) cycle();
    check("s6_addr0", qget(addr_log, 0), RESET_PC);
    check("s6_pc0", qget(seen_pc, 0), RESET_PC);
    check("s6_data0", qget(seen_data, 0), mem_word(RESET_PC));
    check("s6_pc1", qget(seen_pc, 1), RESET_PC + 32'd4);

    // randomized traffic
    lat_min = 1; lat_max = 4;
    do_reset(2, 1);
    for (int i = 0; i < 2000; i++) begin
      pc_enable   = ($urandom_range(0, 99) < 80);
      instr_ready = ($urandom_range(0, 99) < 70);
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        redirect = 1'b0;
        do_reset(1 + $urandom_range(0, 1), 1);
      end else begin
        cycle();
      end
    end
    redirect = 1'b0;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
